// File: rtl/mem_port_initiator.sv
// Memory port initiator: arbitrates instruction fetch and load/store requests onto one
// memory port, splitting misaligned data accesses into single-byte transfers.
module mem_port_initiator (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [10:0] if_addr,
    output logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_inst,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [2:0]  ls_func3,
    input  logic [10:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ready,
    output logic        ls_valid,
    output logic [31:0] ls_rdata,
    output logic        m_read,
    output logic        m_write,
    output logic [2:0]  m_func3,
    output logic [10:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DATA  = 3'd2,
        SPLIT = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  func3_q, func3_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] buf_q, buf_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        ls_valid_q, ls_valid_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        m_read_q, m_read_d;
    logic        m_write_q, m_write_d;
    logic [2:0]  m_func3_q, m_func3_d;
    logic [10:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;

    logic [31:0] assembled_s;
    logic [1:0]  last_k_s;
    logic [1:0]  k_next_s;
    logic        misaligned_s;

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b010:  return raw;
            3'b100:  return {24'h000000, raw[7:0]};
            3'b101:  return {16'h0000, raw[15:0]};
            default: return 32'h00000000;
        endcase
    endfunction

    function automatic logic func3_defined(input logic [2:0] f3);
        return (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
    endfunction

    assign ls_ready = (state_q == IDLE) && ls_req;
    assign if_ready = (state_q == IDLE) && if_req && !ls_req;

    // Next-state and next-output computation for the whole initiator.
    always_comb begin
        state_d    = state_q;
        func3_d    = func3_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        k_d        = k_q;
        buf_d      = buf_q;
        if_valid_d = 1'b0;
        if_inst_d  = if_inst_q;
        ls_valid_d = 1'b0;
        ls_rdata_d = ls_rdata_q;
        m_read_d   = m_read_q;
        m_write_d  = m_write_q;
        m_func3_d  = m_func3_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;

        assembled_s = buf_q;
        assembled_s[{k_q, 3'b000} +: 8] = m_rdata[7:0];
        last_k_s = (func3_q[1:0] == 2'b10) ? 2'd3 : 2'd1;
        k_next_s = k_q + 2'd1;
        misaligned_s = ((ls_func3[1:0] == 2'b01) && ls_addr[0]) ||
                       ((ls_func3[1:0] == 2'b10) && (ls_addr[1:0] != 2'b00));

        case (state_q)
            IDLE: begin
                if (ls_req) begin
                    func3_d  = ls_func3;
                    we_d     = ls_we;
                    wdata_d  = ls_wdata;
                    m_addr_d = ls_addr;
                    k_d      = 2'd0;
                    buf_d    = 32'h00000000;
                    if (!func3_defined(ls_func3)) begin
                        state_d   = DATA;
                        m_func3_d = ls_func3;
                        m_read_d  = 1'b0;
                        m_write_d = 1'b0;
                        m_wdata_d = 32'h00000000;
                    end else if (misaligned_s) begin
                        // Byte-wise transfer: lbu for loads, sb for stores.
                        state_d   = SPLIT;
                        m_func3_d = ls_we ? 3'b000 : 3'b100;
                        m_read_d  = !ls_we;
                        m_write_d = ls_we;
                        m_wdata_d = ls_we ? {24'h000000, ls_wdata[7:0]} : 32'h00000000;
                    end else begin
                        state_d   = DATA;
                        m_func3_d = ls_func3;
                        m_read_d  = !ls_we;
                        m_write_d = ls_we;
                        m_wdata_d = ls_we ? ls_wdata : 32'h00000000;
                    end
                end else if (if_req) begin
                    state_d   = FETCH;
                    m_addr_d  = if_addr;
                    m_func3_d = 3'b010;
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                    m_wdata_d = 32'h00000000;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if_inst_d  = m_rdata;
                if_valid_d = 1'b1;
                state_d    = RESP;
            end
            DATA: begin
                ls_valid_d = 1'b1;
                state_d    = RESP;
                m_read_d   = 1'b0;
                m_write_d  = 1'b0;
                m_wdata_d  = 32'h00000000;
                if (!we_q || !func3_defined(func3_q)) begin
                    ls_rdata_d = load_extend(func3_q, m_rdata);
                end else begin
                    ls_rdata_d = ls_rdata_q;
                end
            end
            SPLIT: begin
                buf_d = assembled_s;
                if (k_q == last_k_s) begin
                    ls_valid_d = 1'b1;
                    state_d    = RESP;
                    m_read_d   = 1'b0;
                    m_write_d  = 1'b0;
                    m_wdata_d  = 32'h00000000;
                    if (!we_q) begin
                        ls_rdata_d = load_extend(func3_q, assembled_s);
                    end else begin
                        ls_rdata_d = ls_rdata_q;
                    end
                end else begin
                    k_d       = k_next_s;
                    m_addr_d  = m_addr_q + 11'd1;
                    m_wdata_d = we_q ? {24'h000000, wdata_q[{k_next_s, 3'b000} +: 8]} : 32'h00000000;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                m_read_d  = 1'b0;
                m_write_d = 1'b0;
                m_wdata_d = 32'h00000000;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            func3_q    <= 3'b000;
            we_q       <= 1'b0;
            wdata_q    <= 32'h00000000;
            k_q        <= 2'd0;
            buf_q      <= 32'h00000000;
            if_valid_q <= 1'b0;
            if_inst_q  <= 32'h00000000;
            ls_valid_q <= 1'b0;
            ls_rdata_q <= 32'h00000000;
            m_read_q   <= 1'b0;
            m_write_q  <= 1'b0;
            m_func3_q  <= 3'b000;
            m_addr_q   <= 11'h000;
            m_wdata_q  <= 32'h00000000;
        end else begin
            state_q    <= state_d;
            func3_q    <= func3_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            k_q        <= k_d;
            buf_q      <= buf_d;
            if_valid_q <= if_valid_d;
            if_inst_q  <= if_inst_d;
            ls_valid_q <= ls_valid_d;
            ls_rdata_q <= ls_rdata_d;
            m_read_q   <= m_read_d;
            m_write_q  <= m_write_d;
            m_func3_q  <= m_func3_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
        end
    end

    assign if_valid = if_valid_q;
    assign if_inst  = if_inst_q;
    assign ls_valid = ls_valid_q;
    assign ls_rdata = ls_rdata_q;
    assign m_read   = m_read_q;
    assign m_write  = m_write_q;
    assign m_func3  = m_func3_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;

endmodule

// File: tb/tb_mem_port_initiator.sv
// Directed bench for mem_port_initiator with a byte-addressed memory model on the memory port.
module tb_mem_port_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [10:0] if_addr;
    logic        if_ready, if_valid;
    logic [31:0] if_inst;
    logic        ls_req, ls_we;
    logic [2:0]  ls_func3;
    logic [10:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_ready, ls_valid;
    logic [31:0] ls_rdata;
    logic        m_read, m_write;
    logic [2:0]  m_func3;
    logic [10:0] m_addr;
    logic [31:0] m_wdata, m_rdata;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [0:2047];
    logic [10:0] wr_log_addr[$];
    logic [7:0]  wr_log_data[$];
    logic [2:0]  wr_log_f3[$];
    logic [10:0] rd_log_addr[$];

    mem_port_initiator dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_valid(if_valid), .if_inst(if_inst),
        .ls_req(ls_req), .ls_we(ls_we), .ls_func3(ls_func3), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ready(ls_ready), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
        .m_read(m_read), .m_write(m_write), .m_func3(m_func3), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Combinational memory read, right-justified by access size.
    always_comb begin
        case (m_func3[1:0])
            2'b00:   m_rdata = {24'h000000, mem[m_addr]};
            2'b01:   m_rdata = {16'h0000, mem[m_addr + 11'd1], mem[m_addr]};
            default: m_rdata = {mem[m_addr + 11'd3], mem[m_addr + 11'd2], mem[m_addr + 11'd1], mem[m_addr]};
        endcase
    end

    // Memory writes and access logging.
    always @(posedge clk) begin
        if (m_read) rd_log_addr.push_back(m_addr);
        if (m_write) begin
            wr_log_addr.push_back(m_addr);
            wr_log_data.push_back(m_wdata[7:0]);
            wr_log_f3.push_back(m_func3);
            case (m_func3[1:0])
                2'b00: mem[m_addr] <= m_wdata[7:0];
                2'b01: begin
                    mem[m_addr]         <= m_wdata[7:0];
                    mem[m_addr + 11'd1] <= m_wdata[15:8];
                end
                default: begin
                    mem[m_addr]         <= m_wdata[7:0];
                    mem[m_addr + 11'd1] <= m_wdata[15:8];
                    mem[m_addr + 11'd2] <= m_wdata[23:16];
                    mem[m_addr + 11'd3] <= m_wdata[31:24];
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [10:0] a, input logic [7:0] d);
        mem[a] <= d;
    endtask

    task automatic clear_logs();
        wr_log_addr.delete();
        wr_log_data.delete();
        wr_log_f3.delete();
        rd_log_addr.delete();
    endtask

    task automatic do_ls(input logic we, input logic [2:0] f3, input logic [10:0] a,
                         input logic [31:0] wd, input int exp_lat, input string tag);
        int n;
        @(negedge clk);
        ls_req = 1'b1; ls_we = we; ls_func3 = f3; ls_addr = a; ls_wdata = wd;
        #1;
        check({tag, "_rdy"}, {31'h0, ls_ready}, 32'd1);
        @(negedge clk);
        ls_req = 1'b0;
        n = 1;
        while (!ls_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic do_fetch(input logic [10:0] a, input string tag);
        int n;
        @(negedge clk);
        if_req = 1'b1; if_addr = a;
        #1;
        check({tag, "_rdy"}, {31'h0, if_ready}, 32'd1);
        @(negedge clk);
        if_req = 1'b0;
        check({tag, "_maddr"}, {21'h0, m_addr}, {21'h0, a});
        check({tag, "_mstb"}, {30'h0, m_read, m_write}, 32'd0);
        n = 1;
        while (!if_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd2);
    endtask

    initial begin
        int n;
        logic seen_valid;
        for (int i = 0; i < 2048; i++) mem[i] <= 8'h00;
        rst = 1'b1; if_req = 1'b0; if_addr = 11'h000;
        ls_req = 1'b0; ls_we = 1'b0; ls_func3 = 3'b000; ls_addr = 11'h000; ls_wdata = 32'h0;
        poke(11'h004, 8'h93); poke(11'h005, 8'h00); poke(11'h006, 8'hA0); poke(11'h007, 8'h00);
        poke(11'h000, 8'hEF); poke(11'h001, 8'hBE); poke(11'h002, 8'hAD); poke(11'h003, 8'hDE);
        poke(11'h008, 8'hF6);
        repeat (3) @(negedge clk);
        check("rst_strobes", {27'h0, if_valid, ls_valid, m_read, m_write, if_ready}, 32'd0);
        check("rst_data", if_inst | ls_rdata | m_wdata | {21'h0, m_addr} | {29'h0, m_func3}, 32'd0);
        rst = 1'b0;

        // Fetch at 0x004.
        do_fetch(11'h004, "fetch");
        check("fetch_inst", if_inst, 32'h00A00093);

        // Simultaneous requests: load wins, fetch accepted three cycles later.
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_func3 = 3'b010; ls_addr = 11'h000;
        if_req = 1'b1; if_addr = 11'h004;
        #1;
        check("arb_rdy", {30'h0, ls_ready, if_ready}, 32'd2);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == 1) ls_req = 1'b0;
            if (i == 1) check("arb_busy", {31'h0, if_ready}, 32'd0);
            if (i == 2) check("arb_lw", ls_valid ? ls_rdata : 32'hBAD0BAD0, 32'hDEADBEEF);
        end
        check("arb_if_rdy", {31'h0, if_ready}, 32'd1);
        @(negedge clk);
        if_req = 1'b0;
        n = 1;
        while (!if_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("arb_if_lat", 32'(n), 32'd2);
        check("arb_if_inst", if_inst, 32'h00A00093);

        // Byte loads, signed and unsigned.
        do_ls(1'b0, 3'b000, 11'h008, 32'h0, 2, "lb");
        check("lb_data", ls_rdata, 32'hFFFFFFF6);
        do_ls(1'b0, 3'b100, 11'h008, 32'h0, 2, "lbu");
        check("lbu_data", ls_rdata, 32'h000000F6);

        // Misaligned half load wrapping from 0x7FF to 0x000.
        poke(11'h7FF, 8'h34); poke(11'h000, 8'h92);
        clear_logs();
        do_ls(1'b0, 3'b001, 11'h7FF, 32'h0, 3, "lh_wrap");
        check("lh_wrap_data", ls_rdata, 32'hFFFF9234);
        check("lh_wrap_nrd", 32'(rd_log_addr.size()), 32'd2);
        if (rd_log_addr.size() == 2) begin
            check("lh_wrap_a0", {21'h0, rd_log_addr[0]}, 32'h7FF);
            check("lh_wrap_a1", {21'h0, rd_log_addr[1]}, 32'h000);
        end

        // Misaligned word store: four byte strobes; load result held.
        clear_logs();
        do_ls(1'b1, 3'b010, 11'h001, 32'h11223344, 5, "sw_split");
        check("sw_hold", ls_rdata, 32'hFFFF9234);
        check("sw_nwr", 32'(wr_log_addr.size()), 32'd4);
        if (wr_log_addr.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("sw_a%0d", k), {21'h0, wr_log_addr[k]}, 32'(k + 1));
                check($sformatf("sw_d%0d", k), {24'h0, wr_log_data[k]}, 32'(8'h44 - 8'(k * 8'h11)));
                check($sformatf("sw_f%0d", k), {29'h0, wr_log_f3[k]}, 32'd0);
            end
        end
        check("sw_mem", {mem[4], mem[3], mem[2], mem[1]}, 32'h11223344);

        // Aligned word store and reload.
        do_ls(1'b1, 3'b010, 11'h010, 32'hCAFEF00D, 2, "sw_al");
        do_ls(1'b0, 3'b010, 11'h010, 32'h0, 2, "lw_al");
        check("lw_al_data", ls_rdata, 32'hCAFEF00D);
        do_ls(1'b0, 3'b101, 11'h012, 32'h0, 2, "lhu");
        check("lhu_data", ls_rdata, 32'h0000CAFE);

        // Undefined func3: no strobes, result 0.
        clear_logs();
        do_ls(1'b0, 3'b011, 11'h010, 32'h0, 2, "undef");
        check("undef_data", ls_rdata, 32'h00000000);
        check("undef_nacc", 32'(wr_log_addr.size() + rd_log_addr.size()), 32'd0);

        // Reset during the second byte of a split store.
        poke(11'h007, 8'h77);
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_func3 = 3'b010; ls_addr = 11'h005; ls_wdata = 32'hAABBCCDD;
        @(negedge clk);
        ls_req = 1'b0;
        check("rs_k0", {20'h0, m_write, m_addr}, {20'h0, 1'b1, 11'h005});
        @(negedge clk);
        check("rs_k1", {20'h0, m_write, m_addr}, {20'h0, 1'b1, 11'h006});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rs_strobes", {27'h0, if_valid, ls_valid, m_read, m_write, ls_ready}, 32'd0);
        check("rs_data", if_inst | ls_rdata | m_wdata | {21'h0, m_addr} | {29'h0, m_func3}, 32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen_valid = seen_valid | ls_valid | m_write;
        end
        check("rs_abandon", {31'h0, seen_valid}, 32'd0);
        check("rs_mem5", {24'h0, mem[5]}, 32'h000000DD);
        check("rs_mem7", {24'h0, mem[7]}, 32'h00000077);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_initiator.md
MEM_PORT_INITIATOR -- requirements
Module: mem_port_initiator

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset:
- clk, input, 1: single clock.
- rst, input, 1: synchronous, active-high reset.

REQ-002 The module SHALL have the following fetch requester ports:
- if_req, input, 1: instruction fetch request.
- if_addr, input, 11: byte address of the fetch.
- if_ready, output, 1: fetch request accepted this cycle.
- if_valid, output, 1: if_inst is valid (one-cycle pulse).
- if_inst, output, 32: fetched word.

REQ-003 The module SHALL have the following load/store requester ports:
- ls_req, input, 1: data request.
- ls_we, input, 1: 1 = store, 0 = load.
- ls_func3, input, 3: access type, encoded as lb/lh/lw/lbu/lhu/sb/sh/sw.
- ls_addr, input, 11: data byte offset.
- ls_wdata, input, 32: store data.
- ls_ready, output, 1: data request accepted this cycle.
- ls_valid, output, 1: access complete (one-cycle pulse).
- ls_rdata, output, 32: extended load result.

REQ-004 The module SHALL have the following memory-side ports:
- m_read, output, 1: data read strobe.
- m_write, output, 1: write strobe.
- m_func3, output, 3: memory access size.
- m_addr, output, 11: memory address.
- m_wdata, output, 32: memory write data.
- m_rdata, input, 32: memory read data, combinational, valid in the same cycle.

Function
REQ-005 The module SHALL implement the states IDLE, FETCH, DATA, SPLIT and RESP.

REQ-006 In IDLE, the module SHALL accept at most one request per cycle, with ls_req taking priority over if_req.
- ls_ready=1 when ls_req=1.
- if_ready=1 only when if_req=1 and ls_req=0.

REQ-007 On acceptance, the module SHALL register the address, func3, we and wdata, then enter:
- FETCH for a fetch;
- DATA for an aligned data access;
- SPLIT for a misaligned data access.

REQ-008 The alignment rules SHALL be:
- Word access is aligned iff addr[1:0]=0.
- Halfword access is aligned iff addr[0]=0.
- Byte access is always aligned.

REQ-009 In FETCH, the module SHALL drive m_addr = the fetch address, m_func3=010, m_read=0 and m_write=0, capture m_rdata into if_inst, and pulse if_valid in the following cycle (RESP).

REQ-010 In DATA, the module SHALL perform one memory cycle with m_func3 = the registered func3, and m_read=!we or m_write=we, never both.

REQ-011 In SPLIT, the module SHALL perform N single-byte accesses, N=4 for a word and N=2 for a half, at addr+k for k=0..N-1, one per cycle, using m_func3=100 (lbu) for loads and 000 (sb) for stores.
- Store byte k SHALL be wdata[8k+7:8k].
- Load byte k SHALL be assembled into bit field [8k+7:8k].

REQ-012 Split address arithmetic SHALL be modulo 2^11; an access at 0x7FF SHALL wrap to 0x000.

REQ-013 After the last DATA/SPLIT cycle, the module SHALL enter RESP and pulse ls_valid for one cycle.
- For loads, ls_rdata SHALL be extended per the registered func3: lb/lh sign-extend from bit 7/15, lbu/lhu zero-extend, lw passes through.
- For stores, ls_rdata SHALL hold its previous value.

REQ-014 Latency from acceptance to valid SHALL be:
- fetch: 2 cycles;
- aligned data: 2 cycles;
- misaligned half: 3 cycles;
- misaligned word: 5 cycles.

REQ-015 RESP SHALL return to IDLE, and a new request SHALL be acceptable in the cycle after RESP; back-to-back throughput is therefore one access per 3 cycles for aligned accesses.

REQ-016 Undefined func3 values (011, 110, 111) SHALL complete as a no-op: no m_read/m_write strobe, ls_valid still pulses, ls_rdata=0.

REQ-017 if_ready and ls_ready SHALL be 0 in every state except IDLE; requests held high during a busy state SHALL wait without loss.

REQ-018 m_read, m_write and m_wdata SHALL be 0 in IDLE and RESP.

Reset
REQ-019 When rst=1 at a clk edge, the module SHALL enter IDLE and abandon any in-flight access with no valid pulse.

REQ-020 Reset values SHALL be: all ready/valid/strobe outputs 0; if_inst, ls_rdata, m_addr, m_func3 and m_wdata all 0.

REQ-021 A store already split SHALL NOT be resumed after reset; bytes already written remain in memory.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Fetch at 0x004 with memory word 0x00A00093 -> if_valid 2 cycles after if_ready, if_inst=0x00A00093.
- if_req and ls_req (lw at 0x000) asserted together -> ls_ready first; if_ready 3 cycles later.
- lb at 0x008 with byte 0xF6 -> ls_rdata=0xFFFFFFF6; lbu at the same address -> 0x000000F6.
- sw 0x11223344 at 0x001 (misaligned) -> four sb strobes at 0x001..0x004 with data 0x44, 0x33, 0x22, 0x11; ls_valid 5 cycles after accept.
- lh at 0x7FF with bytes [0x7FF]=0x34, [0x000]=0x92 -> accesses 0x7FF then 0x000; ls_rdata=0xFFFF9234.
- rst asserted during the second SPLIT cycle -> next cycle IDLE, no ls_valid, all outputs 0.
